seq_mul: RTL
============

# seq_mul

Parametrised sequential radix-2 shift-add multiplier that replaces the fixed 8-bit combinational multiplier in the arithmetic datapath wherever area matters more than latency. It accepts one operand pair per `start` pulse, iterates one partial product per clock, and returns a full-width product with a one-cycle `done` strobe. An optional compile-time feature adds a runtime-selectable two's-complement mode.

## Interface
- `WIDTH`, 8, operand width in bits; legal range 2..32; product is 2*WIDTH bits.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request; sampled only when `busy`=0.
- `x`  in  WIDTH  multiplicand, captured on accepted `start`.
- `y`  in  WIDTH  multiplier, captured on accepted `start`.
- `sgn`  in  1  signed-mode select, captured with operands (present only with `SEQ_MUL_SIGNED_EN`).
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle strobe; `p` valid.
- `p`  out  2*WIDTH  product; held stable from `done` until the next accepted `start` completes.

## Operation
- States: IDLE, RUN. IDLE -> RUN on `start`=1. RUN -> IDLE when the iteration counter reaches WIDTH-1.
- Accept: in IDLE, `start`=1 latches `x` into multiplicand reg, `y` into shift reg, clears accumulator, clears counter, sets `busy`.
- RUN, each cycle: if shift-reg LSB=1, add multiplicand (zero-extended to WIDTH+1) to the accumulator's upper half; shift {carry, accumulator, shift reg} right by one; counter +1.
- Final RUN cycle: write the result to `p`, assert `done`, clear `busy`.
- `start` while `busy`=1: ignored, no queueing, operands not re-sampled.
- Arithmetic: unsigned, exact; max 255*255 = 65025 fits in 16 bits, no overflow possible for any WIDTH.
- Counter width: clog2(WIDTH) bits, never wraps within an operation.

## Timing
- Reset values: `busy`=0, `done`=0, `p`=0, state IDLE, counter 0.
- `start` sampled at edge E0 -> `busy`=1 after E0; iterations on edges E1..E_WIDTH; `done`=1 and `p` valid after E_WIDTH; `done` low after E_WIDTH+1. Latency = WIDTH cycles from the accepting edge (8 for default).
- Back-to-back: `start` high in the `done` cycle is accepted (state is IDLE); throughput one product per WIDTH+1 cycles.
- `rst_n`=0 mid-operation: abort on that edge, all outputs return to reset values, no `done` emitted.
- `start` and `rst_n`=0 on the same edge: reset wins.

## Configuration
- `SEQ_MUL_SIGNED_EN` defined: `sgn` port exists. With `sgn`=1, operands are two's complement. At accept, magnitudes are captured (|-2^(WIDTH-1)| = 2^(WIDTH-1) fits in WIDTH unsigned bits) and sign = x[MSB]^y[MSB] is stored. The final cycle writes the negated product when sign=1. Latency is unchanged. With `sgn`=0, behaviour is identical to the unsigned build.
- Not defined: no `sgn` port and no sign logic; unsigned only.

## Structure
- `seq_mul_pkg`: state enum typedef (IDLE, RUN) and a `SEQ_MUL_MAX_WIDTH`=32 constant used for the parameter check.
- One sub-module, `seq_mul_dp`: accumulator, shift register, adder and optional sign fix-up. The top level keeps the FSM, counter and handshake.

## Test plan
- Reset then `start` with x=255, y=255 -> `done` exactly 8 cycles after the accepting edge, `p`=65025, `busy` high for exactly 8 cycles.
- Back-to-back pairs 7*11, 123*246, 55*88, 99*66, 77*22, 168*195, with `start` asserted in each `done` cycle -> `p` = 77, 30258, 4840, 6534, 1694, 32760, one `done` per pair.
- `start` re-pulsed with x=1, y=1 mid-run of 7*11 -> ignored; `p`=77 and a single `done`.
- `rst_n`=0 at cycle 4 of 255*255 -> `busy`/`done`/`p` = 0 on the next edge, no `done`; a subsequent 7*11 gives 77.
- `SEQ_MUL_SIGNED_EN`, `sgn`=1: -128*-128 -> `p`=16384; -7*11 -> `p`=16'hFFB3 (-77); 127*-128 -> 16'hC080 (-16256).
- WIDTH=16 build: 65535*65535 -> `p`=32'hFFFE0001 after 16 cycles.

Source files
------------

// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared types and limits for the sequential shift-add multiplier.
// Optional feature macro used across the slice: SEQ_MUL_SIGNED_EN.
package seq_mul_pkg;

    // Largest operand width the multiplier is built for.
    localparam int SEQ_MUL_MAX_WIDTH = 32;

    // Control FSM states.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/seq_mul_if.sv
// seq_mul_if: request/result bundle between a client (master) and seq_mul (slave).
// With SEQ_MUL_SIGNED_EN defined the bundle also carries the signed-mode select.
//
// Handshake: the client raises start with x/y (and sgn) valid; the request is
// accepted on a rising edge only while busy=0 and the operands are captured on
// that edge. A start seen while busy=1 is dropped. done is a one-cycle strobe
// marking p valid; p then holds until the next accepted request completes.
interface seq_mul_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic [WIDTH-1:0]   x;
    logic [WIDTH-1:0]   y;
`ifdef SEQ_MUL_SIGNED_EN
    logic               sgn;
`endif
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] p;

`ifdef SEQ_MUL_SIGNED_EN
    modport master (output start, x, y, sgn, input busy, done, p);
    modport slave  (input start, x, y, sgn, output busy, done, p);
`else
    modport master (output start, x, y, input busy, done, p);
    modport slave  (input start, x, y, output busy, done, p);
`endif

endinterface

// File: rtl/seq_mul_dp.sv
// seq_mul_dp: shift-add datapath (multiplicand, accumulator, multiplier shift
// register, adder, product register). With SEQ_MUL_SIGNED_EN defined it also
// captures operand magnitudes and negates the final product when needed.
module seq_mul_dp
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               last,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
`ifdef SEQ_MUL_SIGNED_EN
    input  logic               sgn,
`endif
    output logic [2*WIDTH-1:0] p
);

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   sr;
    logic [WIDTH-1:0]   x_mag;
    logic [WIDTH-1:0]   y_mag;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]   sr_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] result;
`ifdef SEQ_MUL_SIGNED_EN
    logic               neg;
`endif

    // Operand conditioning at accept: magnitudes in signed mode, raw otherwise.
    // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
`ifdef SEQ_MUL_SIGNED_EN
        x_mag = (sgn && x[WIDTH-1]) ? -x : x;
        y_mag = (sgn && y[WIDTH-1]) ? -y : y;
`else
        x_mag = x;
        y_mag = y;
`endif
    end

    // One partial-product step: conditional add with carry, then shift
    // {carry, acc, sr} right by one. prod is the full product after this step.
    always_comb begin
        sum     = {1'b0, acc} + (sr[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        acc_nxt = sum[WIDTH:1];
        sr_nxt  = {sum[0], sr[WIDTH-1:1]};
        prod    = {acc_nxt, sr_nxt};
`ifdef SEQ_MUL_SIGNED_EN
        result  = neg ? -prod : prod;
`else
        result  = prod;
`endif
    end

    // Datapath registers: capture on load, iterate on step, publish on last.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand <= '0;
            acc   <= '0;
            sr    <= '0;
            p     <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            neg   <= 1'b0;
`endif
        end else if (load) begin
            mcand <= x_mag;
            acc   <= '0;
            sr    <= y_mag;
`ifdef SEQ_MUL_SIGNED_EN
            neg   <= sgn & (x[WIDTH-1] ^ y[WIDTH-1]);
`endif
        end else if (step) begin
            acc <= acc_nxt;
            sr  <= sr_nxt;
            if (last) begin
                p <= result;
            end
        end
    end

endmodule

// File: rtl/seq_mul.sv
// seq_mul: sequential radix-2 shift-add multiplier, one partial product per
// clock, WIDTH cycles from accept to done. Control FSM, iteration counter and
// handshake live here; arithmetic lives in seq_mul_dp.
// Optional feature macro: SEQ_MUL_SIGNED_EN (adds runtime two's-complement mode).
module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    seq_mul_if.slave bus,
    output state_e dbg_state
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > SEQ_MUL_MAX_WIDTH) begin : g_bad_width
        $error("seq_mul: WIDTH out of range 2..32");
    end

    state_e        state;
    logic [CW-1:0] cnt;
    logic          load;
    logic          step;
    logic          last;

    assign dbg_state = state;

    // Datapath strobes derived from the current state.
    always_comb begin
        load = (state == IDLE) && bus.start;
        step = (state == RUN);
        last = (state == RUN) && (cnt == LAST);
    end

    // Control FSM with registered busy/done; reset wins over start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= RUN;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                    end
                end
                RUN: begin
                    if (cnt == LAST) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

    seq_mul_dp #(.WIDTH(WIDTH)) u_dp (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .last  (last),
        .x     (bus.x),
        .y     (bus.y),
`ifdef SEQ_MUL_SIGNED_EN
        .sgn   (bus.sgn),
`endif
        .p     (bus.p)
    );

endmodule
